// File: rtl/reaction_task_sequencer.sv
// reaction_task_sequencer: runs a session of reaction-time trials on the VGA display
// and scores each trial in video frames.
module reaction_task_sequencer #(
  parameter int         NUM_TASKS  = 8,
  parameter int         DELAY_MIN  = 30,
  parameter logic [7:0] DELAY_MASK = 8'h3F,
  parameter int         TIMEOUT    = 90,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       fire,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  output logic       rect_enable,
  output logic       task_active,
  output logic [7:0] reaction_frames,
  output logic [3:0] hits,
  output logic [3:0] misses,
  output logic [3:0] task_idx,
  output logic       done,
  output logic [2:0] state
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] SHOW = 3'd3;
  localparam logic [2:0] NEXT = 3'd4;
  localparam logic [2:0] DONE = 3'd5;
  logic [7:0] lfsr;
  logic [7:0] show_cnt;
  logic [8:0] delay_cnt;
  logic       hv_prev;
  logic       hv_zero;
  logic       frame_tick;
  logic       lfsr_fb;
  assign hv_zero    = (hCount == 10'd0) && (vCount == 10'd0);
  // edge-detect so a pixel held for several clocks still yields a single tick
  assign frame_tick = hv_zero && !hv_prev;
  assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      rect_enable     <= 1'b0;
      task_active     <= 1'b0;
      reaction_frames <= 8'd0;
      hits            <= 4'd0;
      misses          <= 4'd0;
      task_idx        <= 4'd0;
      done            <= 1'b0;
      lfsr            <= LFSR_SEED;
      show_cnt        <= 8'd0;
      delay_cnt       <= 9'd0;
      hv_prev         <= 1'b0;
    end else begin
      lfsr    <= {lfsr[6:0], lfsr_fb};
      hv_prev <= hv_zero;
      case (state)
        IDLE, DONE: if (start) begin
          state           <= LOAD;
          task_active     <= 1'b1;
          done            <= 1'b0;
          hits            <= 4'd0;
          misses          <= 4'd0;
          task_idx        <= 4'd0;
          reaction_frames <= 8'd0;
        end
        LOAD: begin
          delay_cnt <= 9'(DELAY_MIN) + {1'b0, lfsr & DELAY_MASK};
          state     <= WAIT;
        end
        // a press before the rectangle is visible is a false start, even on the show tick
        WAIT: if (fire) begin
          misses          <= misses + 4'd1;
          reaction_frames <= 8'hFF;
          state           <= NEXT;
        end else if (frame_tick) begin
          if (delay_cnt == 9'd0) begin
            state       <= SHOW;
            rect_enable <= 1'b1;
            show_cnt    <= 8'd0;
          end else begin
            delay_cnt <= delay_cnt - 9'd1;
          end
        end
        SHOW: if (fire) begin
          hits            <= hits + 4'd1;
          reaction_frames <= show_cnt;
          rect_enable     <= 1'b0;
          state           <= NEXT;
        end else if (frame_tick) begin
          if (show_cnt == 8'(TIMEOUT - 1)) begin
            misses          <= misses + 4'd1;
            reaction_frames <= 8'hFF;
            rect_enable     <= 1'b0;
            state           <= NEXT;
          end else begin
            show_cnt <= show_cnt + 8'd1;
          end
        end
        NEXT: if (task_idx == 4'(NUM_TASKS - 1)) begin
          state       <= DONE;
          done        <= 1'b1;
          task_active <= 1'b0;
        end else begin
          task_idx <= task_idx + 4'd1;
          state    <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reaction_task_sequencer.sv
// tb_reaction_task_sequencer: directed and random trials against a tick-counting
// reference model of the trial rules, on a short 16-clock VGA frame.
module tb_reaction_task_sequencer;
  localparam int         N    = 3;
  localparam int         DMIN = 2;
  localparam logic [7:0] MASK = 8'h00;
  localparam int         TO   = 5;
  localparam logic [7:0] SEED = 8'hA5;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       fire = 1'b0;
  logic [3:0] pc = 4'd0;
  logic [9:0] hCount, vCount;
  logic       rect_enable, task_active, done;
  logic [7:0] reaction_frames;
  logic [3:0] hits, misses, task_idx;
  logic [2:0] state;
  int total = 0;
  int bad = 0;
  int m_st, m_k, m_d;
  logic [3:0] m_hits, m_miss, m_idx;
  logic [7:0] m_rf, m_lfsr;
  logic m_rect, m_active, m_done, m_prev, last_tk;
  reaction_task_sequencer #(
    .NUM_TASKS(N), .DELAY_MIN(DMIN), .DELAY_MASK(MASK), .TIMEOUT(TO), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .fire(fire), .hCount(hCount), .vCount(vCount),
    .rect_enable(rect_enable), .task_active(task_active), .reaction_frames(reaction_frames),
    .hits(hits), .misses(misses), .task_idx(task_idx), .done(done), .state(state)
  );
  always #5 clk = ~clk;
  // each pixel lasts two clocks, so the origin is held for two cycles per frame
  always @(posedge clk) pc <= pc + 4'd1;
  assign hCount = {8'd0, pc[2:1]};
  assign vCount = {9'd0, pc[3]};
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic model_reset();
    m_st = 0; m_k = 0; m_d = 0;
    m_hits = 0; m_miss = 0; m_idx = 0; m_rf = 0;
    m_rect = 0; m_active = 0; m_done = 0; m_prev = 0;
    m_lfsr = SEED;
  endtask
  // m_k counts frame ticks since the trial was loaded; the rectangle appears on tick m_d+1
  task automatic model_step(input logic s, input logic f, input logic tk);
    case (m_st)
      0, 5: if (s) begin
        m_st = 1; m_hits = 0; m_miss = 0; m_idx = 0; m_rf = 0; m_done = 0; m_active = 1;
      end
      1: begin m_k = 0; m_d = DMIN + int'(m_lfsr & MASK); m_st = 2; end
      2: if (f) begin m_miss++; m_rf = 8'hFF; m_st = 4; end
         else if (tk) begin m_k++; if (m_k == m_d + 1) begin m_st = 3; m_rect = 1; end end
      3: if (f) begin m_hits++; m_rf = 8'(m_k - m_d - 1); m_rect = 0; m_st = 4; end
         else if (tk) begin
           m_k++;
           if (m_k == m_d + 1 + TO) begin m_miss++; m_rf = 8'hFF; m_rect = 0; m_st = 4; end
         end
      4: if (m_idx == 4'(N - 1)) begin m_st = 5; m_done = 1; m_active = 0; end
         else begin m_idx++; m_st = 1; end
      default: ;
    endcase
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  endtask
  task automatic step(input logic s, input logic f, input logic fot);
    logic hvz;
    hvz = (hCount == 10'd0) && (vCount == 10'd0);
    last_tk = hvz && !m_prev;
    m_prev = hvz;
    start = s;
    fire = f | (fot & last_tk);
    model_step(start, fire, last_tk);
    @(posedge clk);
    #1;
    start = 0;
    fire = 0;
    chk("cycle",
        {rect_enable, task_active, reaction_frames, hits, misses, task_idx, done, state, dut.lfsr},
        {m_rect, m_active, m_rf, m_hits, m_miss, m_idx, m_done, 3'(m_st), m_lfsr});
    @(negedge clk);
  endtask
  task automatic run(input int n);
    repeat (n) step(0, 0, 0);
  endtask
  task automatic wait_rect(input logic lvl, input string tag);
    for (int i = 0; i < 200 && rect_enable !== lvl; i++) step(0, 0, 0);
    chk(tag, rect_enable, lvl);
  endtask
  task automatic ticks(input int n);
    int c = 0;
    for (int i = 0; i < 400 && c < n; i++) begin step(0, 0, 0); c += int'(last_tk); end
    chk("tick_bound", c, n);
  endtask
  task automatic fire_on_tick();
    logic hit_tick = 0;
    for (int i = 0; i < 40 && !hit_tick; i++) begin step(0, 0, 1); hit_tick = last_tk; end
    chk("fire_tick_bound", hit_tick, 1);
  endtask
  initial begin
    int c;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_outs", {rect_enable, task_active, reaction_frames, hits, misses, task_idx, done, state}, 0);
    chk("rst_lfsr", dut.lfsr, SEED);
    rst = 1;
    run(5);
    step(1, 0, 0);
    chk("start_load", state, 1);
    wait_rect(1, "t0_rise");
    ticks(2);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("t0_hits", hits, 1);
    chk("t0_rf", reaction_frames, 2);
    chk("t0_idx", task_idx, 1);
    chk("t0_state", state, 1);
    wait_rect(1, "t1_rise");
    c = 0;
    for (int i = 0; i < 200 && rect_enable; i++) begin step(0, 0, 0); c += int'(last_tk); end
    chk("t1_show_ticks", c, TO);
    chk("t1_misses", misses, 1);
    chk("t1_rf", reaction_frames, 8'hFF);
    run(3);
    chk("t2_wait", {rect_enable, state}, {1'b0, 3'd2});
    step(0, 1, 0);
    chk("t2_false", {misses, reaction_frames, state}, {4'd2, 8'hFF, 3'd4});
    step(0, 0, 0);
    chk("done", {done, task_active, state}, {1'b1, 1'b0, 3'd5});
    chk("sum", hits + misses, N);
    chk("done_idx", task_idx, N - 1);
    step(1, 0, 0);
    chk("restart", {state, hits, misses, task_idx, done}, {3'd1, 4'd0, 4'd0, 4'd0, 1'b0});
    step(0, 0, 0);
    step(1, 0, 0);
    chk("start_in_wait", state, 2);
    wait_rect(1, "s2_rise");
    ticks(4);
    fire_on_tick();
    chk("coinc_timeout", {hits, reaction_frames, rect_enable}, {4'd1, 8'd4, 1'b0});
    run(2);
    ticks(2);
    fire_on_tick();
    chk("coinc_show", {misses, reaction_frames, rect_enable, state}, {4'd1, 8'hFF, 1'b0, 3'd4});
    wait_rect(1, "s2_t2_rise");
    run(3);
    #2 rst = 0;
    #1;
    chk("async_rst", {rect_enable, hits, misses, state}, 0);
    model_reset();
    @(negedge clk);
    chk("rst_lfsr2", dut.lfsr, SEED);
    rst = 1;
    run(2);
    chk("after_rst", state, 0);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 23) == 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reaction_task_sequencer.md
Name: reaction_task_sequencer

Overview:
- Sequences the reaction-time tasks shown on the VGA display.
- Decides when the centred gray rectangle is visible by driving the rectangle-enable input of the display colour mux.
- Measures, in video frames, how long the player takes to press fire once the rectangle appears.
- Keeps hit/miss totals for a session of NUM_TASKS trials. Sits between the debounced button logic, the VGA sync counters and the display colour mux.

Parameters:
- NUM_TASKS, 8: trials per session (1..15).
- DELAY_MIN, 30: minimum pre-show delay, frames.
- DELAY_MASK, 8'h3F: mask applied to LFSR value added to DELAY_MIN.
- TIMEOUT, 90: frames in SHOW before a miss is scored (1..254).
- LFSR_SEED, 8'hA5: reset value of delay LFSR (nonzero).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse, debounced; begins a session
- fire  in  1  single-cycle pulse, debounced; player response
- hCount  in  10  horizontal pixel counter from VGA sync
- vCount  in  10  vertical line counter from VGA sync
- rect_enable  out  1  rectangle visible; drives the colour mux enable
- task_active  out  1  session in progress (LOAD/WAIT/SHOW/NEXT)
- reaction_frames  out  8  last trial result: frames from show to fire; 8'hFF = timeout or false start
- hits  out  4  hits this session
- misses  out  4  misses this session
- task_idx  out  4  current trial number, 0-based
- done  out  1  session complete
- state  out  3  FSM state code, for debug LEDs

Behaviour:
- Reset (rst low, async): state=IDLE, all outputs 0, LFSR=LFSR_SEED, internal counters 0.
- frame_tick: one-cycle internal pulse on the first clk where (hCount==0 && vCount==0) is true after being false. Uses a registered previous value, so it is robust to clk running faster than the pixel rate.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Shifts every clk, including in IDLE.
- State encoding: IDLE=0, LOAD=1, WAIT=2, SHOW=3, NEXT=4, DONE=5. All outputs are registered.
- IDLE: start → LOAD; clears hits, misses, task_idx, reaction_frames.
- LOAD, one cycle: delay_cnt <= DELAY_MIN + (lfsr & DELAY_MASK), 9-bit, no overflow → WAIT.
- WAIT:
  - On frame_tick with delay_cnt != 0: delay_cnt decrements.
  - On frame_tick with delay_cnt == 0: → SHOW; rect_enable <= 1; show_cnt <= 0.
  - fire in WAIT is a false start: misses+1, reaction_frames <= 8'hFF → NEXT.
  - fire and the transition tick in the same cycle: false start wins.
- SHOW:
  - Each frame_tick increments show_cnt.
  - fire: hits+1, reaction_frames <= show_cnt, rect_enable <= 0 → NEXT.
  - frame_tick with show_cnt == TIMEOUT-1: misses+1, reaction_frames <= 8'hFF, rect_enable <= 0 → NEXT.
  - fire and timeout tick in the same cycle: fire wins (hit, reaction_frames = TIMEOUT-1).
- NEXT, one cycle:
  - If task_idx == NUM_TASKS-1 → DONE, task_idx holds.
  - Otherwise task_idx+1 → LOAD.
- DONE: done=1; totals hold. start → LOAD, clearing counters exactly as from IDLE (done drops the same cycle).
- start outside IDLE/DONE is ignored. fire outside WAIT/SHOW is ignored.
- rect_enable rises only on a frame_tick. It falls only on fire or timeout, or on async reset (immediate).
- Invariant: hits + misses == task_idx + 1 at NEXT and DONE.
- hits and misses are 4-bit and cannot overflow (NUM_TASKS ≤ 15).

Test Plan (override DELAY_MIN=2, DELAY_MASK=0, TIMEOUT=5, NUM_TASKS=3; VGA counters modelled with a short frame):
- Reset mid-SHOW: rst low → rect_enable, hits, state read 0 in the same cycle; after release, state=IDLE and LFSR=8'hA5.
- start, wait 3 ticks, fire 2 ticks after rect_enable rises → hits=1, reaction_frames=2, task_idx=1, state=LOAD.
- Trial with no fire → rect_enable high for exactly 5 frame_ticks, then misses=1 and reaction_frames=8'hFF.
- fire during WAIT → misses+1, reaction_frames=8'hFF, rect_enable never asserts for that trial.
- fire coincident with the 5th SHOW tick → hit scored, reaction_frames=4. fire coincident with the WAIT→SHOW tick → false-start miss.
- Full session of 3 trials → done=1, hits+misses=3, task_idx=2. start in DONE → counters clear and state=LOAD. start pulse during WAIT → no effect.
